regfile_sequencer: RTL and testbench

Bulk load/dump controller on the RegisterFile ports: drives `writeRegister`/`writeData`/`regWrite` to fill all registers from an input stream, or drives `readRegister1`/`readRegister2` to read every register and send them out an output stream. Used for register-file initialisation at boot and for debug snapshots, in place of hand-written per-register stimulus. It sits between a host/debug link, which uses valid/ready streams, and the RegisterFile, which has asynchronous reads and writes on the rising clock edge.

---
 rtl/regfile_seq_pkg.sv | 20 ++
 rtl/regfile_sequencer.sv | 161 ++++++++++++++++
 tb/tb_regfile_sequencer.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_seq_pkg.sv
// Shared types and defaults for the register-file bulk load/dump sequencer.
package regfile_seq_pkg;

  localparam int NUM_REGS_DEF   = 32;
  localparam int ADDR_WIDTH_DEF = 5;
  localparam int DATA_WIDTH_DEF = 32;

  localparam logic MODE_DUMP = 1'b0;
  localparam logic MODE_LOAD = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE         = 3'd0,
    ST_DUMP_CAPTURE = 3'd1,
    ST_DUMP_SEND0   = 3'd2,
    ST_DUMP_SEND1   = 3'd3,
    ST_LOAD         = 3'd4,
    ST_DONE         = 3'd5
  } state_e;

endpackage

// File: rtl/regfile_sequencer.sv
// Bulk load/dump controller: fills every RegisterFile entry from an input stream,
// or reads every entry pairwise and emits it on an output stream.
module regfile_sequencer
  import regfile_seq_pkg::*;
#(
  parameter int NUM_REGS   = NUM_REGS_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  mode,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] readRegister1,
  output logic [ADDR_WIDTH-1:0] readRegister2,
  input  logic [DATA_WIDTH-1:0] readData1,
  input  logic [DATA_WIDTH-1:0] readData2,
  output logic [ADDR_WIDTH-1:0] writeRegister,
  output logic [DATA_WIDTH-1:0] writeData,
  output logic                  regWrite,
  input  logic [DATA_WIDTH-1:0] inData,
  input  logic                  inValid,
  output logic                  inReady,
  output logic [DATA_WIDTH-1:0] outData,
  output logic                  outValid,
  input  logic                  outReady,
  output logic [2:0]            dbg_state
);

  // Streams use valid/ready: a beat transfers on a rising edge where both are high;
  // the source holds data and valid stable until that edge.

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX  = ADDR_WIDTH'(NUM_REGS - 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_PAIR = ADDR_WIDTH'(NUM_REGS / 2 - 1);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] k_q, k_d;
  logic [DATA_WIDTH-1:0] b1_q, b1_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                  out_valid_q, out_valid_d;
  logic [ADDR_WIDTH-1:0] rd_addr1_q, rd_addr1_d;
  logic [ADDR_WIDTH-1:0] rd_addr2_q, rd_addr2_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic                  reg_write_q, reg_write_d;
  logic                  in_ready_q, in_ready_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    b1_d        = b1_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    rd_addr1_d  = rd_addr1_q;
    rd_addr2_d  = rd_addr2_q;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    reg_write_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        k_d = '0;
        if (start) state_d = (mode == MODE_LOAD) ? ST_LOAD : ST_DUMP_CAPTURE;
      end
      ST_DUMP_CAPTURE: begin
        // Word b0 goes straight into the output register; b1 waits in its buffer.
        out_data_d  = readData1;
        b1_d        = readData2;
        out_valid_d = 1'b1;
        state_d     = ST_DUMP_SEND0;
      end
      ST_DUMP_SEND0: begin
        if (outReady) begin
          out_data_d = b1_q;
          state_d    = ST_DUMP_SEND1;
        end
      end
      ST_DUMP_SEND1: begin
        if (outReady) begin
          out_valid_d = 1'b0;
          if (k_q == LAST_PAIR) begin
            state_d = ST_DONE;
          end else begin
            k_d     = k_q + 1'b1;
            state_d = ST_DUMP_CAPTURE;
          end
        end
      end
      ST_LOAD: begin
        if (inValid) begin
          wr_addr_d   = k_q;
          wr_data_d   = inData;
          reg_write_d = 1'b1;
          k_d         = k_q + 1'b1;
          if (k_q == LAST_IDX) state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Addresses are set on entry so they are stable for the whole capture cycle.
    if (state_d == ST_DUMP_CAPTURE) begin
      rd_addr1_d = {k_d[ADDR_WIDTH-2:0], 1'b0};
      rd_addr2_d = {k_d[ADDR_WIDTH-2:0], 1'b1};
    end

    in_ready_d = (state_d == ST_LOAD);
    busy_d     = (state_d != ST_IDLE);
    done_d     = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      k_q         <= '0;
      b1_q        <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      rd_addr1_q  <= '0;
      rd_addr2_q  <= '0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      reg_write_q <= 1'b0;
      in_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      b1_q        <= b1_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      rd_addr1_q  <= rd_addr1_d;
      rd_addr2_q  <= rd_addr2_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      reg_write_q <= reg_write_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign readRegister1 = rd_addr1_q;
  assign readRegister2 = rd_addr2_q;
  assign writeRegister = wr_addr_q;
  assign writeData     = wr_data_q;
  assign regWrite      = reg_write_q;
  assign inReady       = in_ready_q;
  assign outData       = out_data_q;
  assign outValid      = out_valid_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_regfile_sequencer.sv
// Directed bench for regfile_sequencer with a behavioural RegisterFile alongside it.
module tb_regfile_sequencer;
  import regfile_seq_pkg::*;

  localparam int NR = 32;
  localparam int AW = 5;
  localparam int DW = 32;

  logic          clk;
  logic          reset;
  logic          start;
  logic          mode;
  logic          busy;
  logic          done;
  logic [AW-1:0] readRegister1;
  logic [AW-1:0] readRegister2;
  logic [DW-1:0] readData1;
  logic [DW-1:0] readData2;
  logic [AW-1:0] writeRegister;
  logic [DW-1:0] writeData;
  logic          regWrite;
  logic [DW-1:0] inData;
  logic          inValid;
  logic          inReady;
  logic [DW-1:0] outData;
  logic          outValid;
  logic          outReady;
  logic [2:0]    dbg_state;

  logic [DW-1:0] rf [NR];
  logic [DW-1:0] exp_q[$];

  int n_cmp = 0;
  int n_err = 0;

  regfile_sequencer #(.NUM_REGS(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .busy(busy), .done(done),
    .readRegister1(readRegister1), .readRegister2(readRegister2),
    .readData1(readData1), .readData2(readData2),
    .writeRegister(writeRegister), .writeData(writeData), .regWrite(regWrite),
    .inData(inData), .inValid(inValid), .inReady(inReady),
    .outData(outData), .outValid(outValid), .outReady(outReady),
    .dbg_state(dbg_state)
  );

  // Behavioural RegisterFile: asynchronous reads, write on rising edge.
  assign readData1 = rf[readRegister1];
  assign readData2 = rf[readRegister2];
  always @(posedge clk) if (regWrite) rf[writeRegister] <= writeData;

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_regwrite"}, regWrite, 0);
    check({tag, "_inready"}, inReady, 0);
    check({tag, "_outvalid"}, outValid, 0);
    check({tag, "_outdata"}, outData, 0);
    check({tag, "_wdata"}, writeData, 0);
    check({tag, "_waddr"}, writeRegister, 0);
    check({tag, "_raddr1"}, readRegister1, 0);
    check({tag, "_raddr2"}, readRegister2, 0);
    check({tag, "_state"}, dbg_state, ST_IDLE);
  endtask

  // Load driver: gap idle cycles between beats; abort>0 resets after that many beats.
  task automatic load_run(input logic [31:0] base, input int gap, input int abort);
    int i;
    int cyc;
    start = 1'b1;
    mode = MODE_LOAD;
    inValid = 1'b0;
    @(negedge clk);
    start = 1'b0;
    check("load_busy", busy, 1);
    check("load_inready", inReady, 1);
    check("load_state", dbg_state, ST_LOAD);
    i = 0;
    cyc = 0;
    while (i < NR && cyc < 300) begin
      inValid = (cyc % (gap + 1) == 0);
      inData = base + i;
      start = (gap > 0 && cyc == 10);
      mode = (gap > 0 && cyc == 10) ? MODE_DUMP : MODE_LOAD;
      @(negedge clk);
      cyc++;
      if (inValid) begin
        check("load_wr", regWrite, 1);
        check("load_waddr", writeRegister, i);
        check("load_wdata", writeData, base + i);
        check("load_done", done, (i == NR - 1));
        i++;
        if (abort > 0 && i == abort) begin
          inValid = 1'b0;
          #2 reset = 1'b1;
          #1 check_idle_outputs("abort");
          @(negedge clk);
          reset = 1'b0;
          @(negedge clk);
          return;
        end
      end else begin
        check("load_gap_wr", regWrite, 0);
      end
    end
    inValid = 1'b0;
    start = 1'b0;
    check("load_beats", i, NR);
    @(negedge clk);
    check("load_end_busy", busy, 0);
    check("load_end_done", done, 0);
    check("load_end_wr", regWrite, 0);
  endtask

  // Dump driver: pattern 0 keeps outReady high; pattern 1 accepts 1-in-3 and stalls word 7.
  task automatic dump_run(input logic [31:0] base, input int pattern);
    int cyc;
    int beats;
    int first_valid;
    int last_beat;
    int done_cyc;
    int stall_left;
    logic prev_stall;
    logic [31:0] prev_data;
    logic [31:0] e;
    for (int j = 0; j < NR; j++) exp_q.push_back(base + j);
    start = 1'b1;
    mode = MODE_DUMP;
    outReady = (pattern == 0);
    @(negedge clk);
    start = 1'b0;
    check("dump_busy", busy, 1);
    cyc = 1;
    beats = 0;
    first_valid = -1;
    last_beat = -1;
    done_cyc = -1;
    stall_left = 5;
    prev_stall = 1'b0;
    prev_data = '0;
    while (done_cyc < 0 && cyc < 400) begin
      if (outValid && first_valid < 0) first_valid = cyc;
      if (prev_stall) check("dump_hold", outData, prev_data);
      if (pattern == 1 && outValid && beats == 7) check("dump_w7", outData, base + 7);
      if (done) done_cyc = cyc;
      if (pattern == 0) outReady = 1'b1;
      else if (outValid && beats == 7 && stall_left > 0) begin
        outReady = 1'b0;
        stall_left--;
      end else outReady = (cyc % 3 == 0);
      if (outValid && outReady) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
        check("dump_data", outData, e);
        beats++;
        last_beat = cyc;
        prev_stall = 1'b0;
      end else begin
        prev_stall = outValid;
      end
      prev_data = outData;
      @(negedge clk);
      cyc++;
    end
    outReady = 1'b0;
    check("dump_done_seen", (done_cyc >= 0), 1);
    check("dump_beats", beats, NR);
    check("dump_exp_empty", exp_q.size(), 0);
    if (pattern == 0) begin
      check("dump_first_valid", first_valid, 2);
      check("dump_last_beat", last_beat, 3 * NR / 2);
      check("dump_done_cyc", done_cyc, 3 * NR / 2 + 1);
    end
    check("dump_end_busy", busy, 0);
    exp_q.delete();
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    mode = MODE_DUMP;
    inData = '0;
    inValid = 1'b0;
    outReady = 1'b0;
    #3 check_idle_outputs("por");
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    load_run(32'h100, 0, 0);
    check("rf31", rf[31], 32'h11F);
    check("rf0", rf[0], 32'h100);

    dump_run(32'h100, 0);
    dump_run(32'h100, 1);

    load_run(32'h200, 2, 0);
    check("gap_rf5", rf[5], 32'h205);
    check("gap_rf31", rf[31], 32'h21F);

    load_run(32'h300, 0, 10);
    load_run(32'hA0, 0, 0);
    for (int j = 0; j < NR; j++) check("reload_rf", rf[j], 32'hA0 + j);

    dump_run(32'hA0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
